// File: rtl/arb_mux_rr_pkg.sv
// Shared definitions for the round-robin / forced-select arbitrating mux.
package arb_mux_rr_pkg;

  // Selection mode encodings
  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FORCE = 1'b1;

  // Default geometry
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 8;
  localparam int DEF_SELW  = 3;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational grant logic: rotating priority from ptr, or forced select.
module rr_arbiter
  import arb_mux_rr_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int SELW = DEF_SELW
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any_grant
);

  logic [NCH-1:0] hi_mask;
  logic [NCH-1:0] hi_req;
  logic [NCH-1:0] pick;

  // Requests at or above ptr win first; otherwise wrap to the lowest request.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NCH; i++) hi_mask[i] = (SELW'(i) >= ptr);
    hi_req = req & hi_mask;
    pick   = (|hi_req) ? hi_req : req;
  end

  // One-hot grant: forced select honours only sel, rr takes the lowest picked bit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    if (mode == ARB_MODE_FORCE) begin
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && req[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SELW'(i);
          any_grant = 1'b1;
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (pick[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = SELW'(i);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// Registered N-channel selector with per-channel valid/ready and rr or forced grant.
module arb_mux_rr
  import arb_mux_rr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = DEF_SELW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [NCH-1:0][WIDTH-1:0] ch_data;
  logic [SELW-1:0]           ptr;
  logic [NCH-1:0]            grant;
  logic [SELW-1:0]           grant_idx;
  logic                      any_grant;
  logic                      load_en;
  logic                      xfer;
  logic [WIDTH-1:0]          sel_data;

  assign ch_data = in_data;

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .sel       (sel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Single-entry output register: loadable when empty or draining this cycle.
  assign load_en  = !out_valid || out_ready;
  assign in_ready = (load_en && !rst) ? grant : '0;
  assign xfer     = any_grant && load_en && !rst;

  // AND-OR data select; grant is one-hot or zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++) sel_data |= ch_data[i] & {WIDTH{grant[i]}};
  end

  // Output register and rr pointer; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      if (mode == ARB_MODE_RR)
        ptr <= (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed-vector bench for arb_mux_rr (NCH=8) plus an NCH=6 instance for sel range.
module tb_arb_mux_rr;
  import arb_mux_rr_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [2:0]        sel;
  logic [7:0][15:0]  din;
  logic [7:0]        in_valid;
  logic [7:0]        in_ready;
  logic [15:0]       out_data;
  logic [2:0]        out_sel;
  logic              out_valid;
  logic              out_ready;

  logic [5:0][15:0]  din6;
  logic [5:0]        in_valid6;
  logic [5:0]        in_ready6;
  logic [15:0]       out_data6;
  logic [2:0]        out_sel6;
  logic              out_valid6;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  arb_mux_rr #(.WIDTH(16), .NCH(8), .SELW(3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(din), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  arb_mux_rr #(.WIDTH(16), .NCH(6), .SELW(3)) dut6 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(din6), .in_valid(in_valid6), .in_ready(in_ready6),
    .out_data(out_data6), .out_sel(out_sel6), .out_valid(out_valid6),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] s, input logic [15:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    rst       = 1'b1;
    mode      = ARB_MODE_RR;
    sel       = 3'd0;
    out_ready = 1'b1;
    in_valid  = 8'hFF;
    in_valid6 = 6'h3F;
    for (int i = 0; i < 8; i++) din[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 6; i++) din6[i] = 16'h2000 + 16'(i);

    // Reset held for two edges with every channel valid
    step();
    step();
    settle();
    chk("rst.in_ready",  32'(in_ready),  32'h00);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'h0);
    chk("rst.out_sel",   32'(out_sel),   32'd0);
    chk("rst.in_ready6", 32'(in_ready6), 32'h00);

    // Release: channel 0 first, then 1..7,0 at one word per cycle
    rst = 1'b0;
    settle();
    chk("rr.first_ready", 32'(in_ready), 32'h01);
    for (int k = 0; k < 9; k++) begin
      step();
      chk_out($sformatf("rr%0d", k), 3'(k % 8), 16'h1000 + 16'(k % 8));
    end
    // ptr = 1 now; a lone request on channel 2 moves ptr to 3
    in_valid = 8'b0000_0100;
    step();
    chk_out("sp.ch2", 3'd2, 16'h1002);

    // Sparse: channels 2 and 5 only, ptr=3 -> 5, 2, 5
    in_valid = 8'b0010_0100;
    settle();
    chk("sp.rdy5a", 32'(in_ready), 32'h20);
    step();
    chk_out("sp.g5a", 3'd5, 16'h1005);
    chk("sp.rdy2", 32'(in_ready), 32'h04);
    step();
    chk_out("sp.g2", 3'd2, 16'h1002);
    chk("sp.rdy5b", 32'(in_ready), 32'h20);
    step();
    chk_out("sp.g5b", 3'd5, 16'h1005);

    // Nothing valid with out_ready=1: drain to empty, ptr stays at 6
    in_valid = 8'h00;
    step();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: load BEEF from channel 3, then stall four cycles
    din[3]   = 16'hBEEF;
    in_valid = 8'b0000_1000;
    settle();
    chk("bp.rdy3", 32'(in_ready), 32'h08);
    step();
    chk_out("bp.load", 3'd3, 16'hBEEF);
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("bp.rdy%0d", k), 32'(in_ready), 32'h00);
      step();
      chk_out($sformatf("bp.hold%0d", k), 3'd3, 16'hBEEF);
    end
    // Release: ptr=4 so channel 4 loads in the same cycle BEEF drains
    out_ready = 1'b1;
    settle();
    chk("bp.rdy_rel", 32'(in_ready), 32'h10);
    step();
    chk_out("bp.next", 3'd4, 16'h1004);

    // Forced select 6 with channels 1 and 6 valid; ptr stays at 5
    din[6]   = 16'hA5A5;
    mode     = ARB_MODE_FORCE;
    sel      = 3'd6;
    in_valid = 8'b0100_0010;
    settle();
    chk("fs.rdy", 32'(in_ready), 32'h40);
    chk("fs.rdy6_oob", 32'(in_ready6), 32'h00);
    step();
    chk_out("fs.g6a", 3'd6, 16'hA5A5);
    chk("fs.valid6_oob", 32'(out_valid6), 32'd0);
    step();
    chk_out("fs.g6b", 3'd6, 16'hA5A5);
    // Back to rr with 1 and 5 valid: ptr=5 picks 5 (a moved ptr would pick 1)
    mode     = ARB_MODE_RR;
    in_valid = 8'b0010_0010;
    settle();
    chk("fs.ptr_kept", 32'(in_ready), 32'h20);
    step();
    chk_out("fs.rr5", 3'd5, 16'h1005);

    // Reset while a word is held under backpressure
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    rst       = 1'b1;
    settle();
    chk("mr.rdy_in_rst", 32'(in_ready), 32'h00);
    step();
    chk("mr.valid", 32'(out_valid), 32'd0);
    chk("mr.data",  32'(out_data),  32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    settle();
    chk("mr.rdy0", 32'(in_ready), 32'h01);
    step();
    chk_out("mr.g0", 3'd0, 16'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
